// File: rtl/bar_pkg.sv
// Shared definitions for the bar link: word width, word type and the
// modular accumulate helper used by the sink's counter and checksum.
package bar_pkg;

    localparam int BAR_DATA_W = 32;

    typedef logic [BAR_DATA_W-1:0] bar_data_t;

    // Modular add that only takes effect when en is set; the carry out of
    // the top bit is discarded so results wrap naturally.
    function automatic bar_data_t bar_acc(input bar_data_t acc,
                                          input bar_data_t inc,
                                          input logic      en);
        bar_data_t res;
        res = en ? (acc + inc) : acc;
        return res;
    endfunction

endpackage

// File: rtl/bar.sv
// The bar link: one data word with a valid/ready handshake. The producer
// side uses modport out, the consumer side uses modport in.
interface bar;

    bar_pkg::bar_data_t data;
    logic               valid;
    logic               ready;

    modport in  (input  data, input  valid, output ready);
    modport out (output data, output valid, input  ready);

endinterface

// File: rtl/bar_sink_fifo.sv
// Generic first-word-fall-through FIFO. Pointers carry one extra wrap bit
// so full and empty can be told apart without a separate counter.
module bar_sink_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  T                           wdata_i,
    output T                           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    T            mem_q [DEPTH];
    logic        push_eff;
    logic        pop_eff;

    assign empty_o  = (wptr_q == rptr_q);
    assign full_o   = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A flush wins over everything; a push into a full FIFO or a pop from
    // an empty one is dropped here so callers need not gate them.
    assign push_eff = push_i && !full_o  && !flush_i;
    assign pop_eff  = pop_i  && !empty_o && !flush_i;

    assign level_o  = wptr_q - rptr_q;
    assign rdata_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    // Next pointer values: flush to zero, otherwise advance on accepted ops.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_eff) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
            if (pop_eff)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Pointer registers; reset empties the FIFO immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents are only meaningful behind the pointers, so
    // it carries no reset.
    always_ff @(posedge clk_i) begin
        if (push_eff) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/bar_sink.sv
// Receiving end of a bar link: accepts words into a small FWFT FIFO that
// drains through a local pop port, and tracks a transfer count and a
// running modular checksum of accepted words.
module bar_sink
    import bar_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    bar.in                         x,
    input  logic                   clear_i,
    input  logic                   pop_i,
    output bar_data_t              rdata_o,
    output logic                   rvalid_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [CNT_W-1:0]       xfer_cnt_o,
    output bar_data_t              sum_o
);

    logic             full;
    logic             empty;
    logic             ready;
    logic             push;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bar_data_t        sum_q, sum_d;

    // Ready depends only on registered occupancy and clear, so there is no
    // combinational path from pop_i or x.valid, and a full FIFO stays
    // closed even when it is being popped in the same cycle.
    assign ready    = !full && !clear_i;
    assign x.ready  = ready;
    assign push     = x.valid && ready;
    assign rvalid_o = !empty;

    bar_sink_fifo #(
        .DEPTH (DEPTH),
        .T     (bar_data_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clear_i),
        .push_i  (push),
        .pop_i   (pop_i),
        .wdata_i (x.data),
        .rdata_o (rdata_o),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    // Counter and checksum update; the counter reuses the 32-bit helper and
    // is truncated back to CNT_W, which gives wrap modulo 2^CNT_W.
    always_comb begin
        cnt_d = cnt_q;
        sum_d = sum_q;
        if (clear_i) begin
            cnt_d = '0;
            sum_d = '0;
        end else begin
            cnt_d = CNT_W'(bar_acc(bar_data_t'(cnt_q), 32'd1, push));
            sum_d = bar_acc(sum_q, x.data, push);
        end
    end

    // Counter and checksum registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sum_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sum_q <= sum_d;
        end
    end

    assign xfer_cnt_o = cnt_q;
    assign sum_o      = sum_q;

endmodule

// File: doc/bar_sink.md
# bar_sink

Receiving endpoint of a `bar` link. It terminates a `bar.in` modport, accepts words on the valid/ready handshake, and buffers them in a small first-word-fall-through FIFO. The FIFO drains through a local pop port. It also keeps a transfer counter and a running checksum. It sits at the far end of any chain of `bar` pass-through stages, opposite the producer that drives the `bar.out` side.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries. Must be a power of two and ≥2.
- `CNT_W`, 16: width of the transfer counter.

Ports:
- `clk_i`  input  1: single clock, rising edge.
- `rst_ni`  input  1: reset, asynchronous, active-low.
- `x`  interface  `bar.in`: link from the producer. The block reads `x.data` [31:0] and `x.valid`, and drives `x.ready`.
- `clear_i`  input  1: synchronous flush of the FIFO, counter and checksum.
- `pop_i`  input  1: consume the head word.
- `rdata_o`  output  32: head word.
- `rvalid_o`  output  1: FIFO non-empty.
- `level_o`  output  $clog2(DEPTH)+1: current occupancy.
- `xfer_cnt_o`  output  CNT_W: number of accepted transfers.
- `sum_o`  output  32: running checksum of accepted words.

## Operation
- **Accept:** a transfer occurs on a rising edge where `x.valid && x.ready`. The word is written at the tail, `xfer_cnt_o` += 1, and `sum_o` += `x.data`.
- **Ready:** `x.ready = !full && !clear_i`.
  - Driven from registered occupancy plus `clear_i` only.
  - No combinational path from `pop_i` or `x.valid`.
  - No full-bypass: when full, a same-cycle pop does not let a push in.
- **Pop:** effective pop = `pop_i && rvalid_o`. A pop while empty is ignored.
- **Head word:** `rdata_o` shows the head entry combinationally (first-word-fall-through). It is 0 when empty.
- **Occupancy:** `level_o` += push, −= pop.
  - Push and pop together leave `level_o` unchanged.
  - Read and write pointers carry one extra bit for the full/empty distinction and wrap at DEPTH.
- **Arithmetic:** `xfer_cnt_o` wraps modulo 2^CNT_W. `sum_o` is a 32-bit modular add with carry discarded.
- **Clear:** when `clear_i` is high on an edge:
  - pointers, level, counter and sum go to 0;
  - any pop in that cycle is discarded;
  - no transfer is accepted, because `x.ready` is low.
- **Reset values:** all outputs 0, so `x.ready` = 1 once out of reset.
- **Reset mid-operation:** asserting `rst_ni` low returns every register to its reset value immediately, without waiting for a clock edge. Buffered words are lost. The producer must treat any transfer that did not complete before reset as not accepted.

## Timing
- **Push-to-read latency:** 1 cycle. A word accepted at edge N appears on `rdata_o`/`rvalid_o` after edge N.
- **Pop latency:** a pop at edge N exposes the next entry after edge N.
- **Full:** after the DEPTH-th accepted word with no pops, `x.ready` is low in the following cycle. It returns high one cycle after the first effective pop.
- **Empty with push and pop in the same cycle:** the pop is ignored and the push lands, so `level_o` = 1.
- **Producer obligation:** `x.data` stays stable while `x.valid && !x.ready`. The block does not check this.
- **Throughput:** with continuous pops, one word per cycle is sustained indefinitely.

## Structure
- **Package `bar_pkg`:**
  - `BAR_DATA_W` = 32;
  - `bar_data_t` = logic [BAR_DATA_W-1:0];
  - the shared helper function for the counter and checksum update.
  - The `bar` interface declaration uses the same constant.
- **Sub-module `bar_sink_fifo`:** generic FWFT storage.
  - Ports: push/pop/flush, `wdata`, `rdata`, `full`/`empty`, level.
  - Parameterised by DEPTH and element type.
- **Top level:** `bar_sink` holds the handshake decode, counter and checksum around one `bar_sink_fifo` instance.

## Test plan
- **Reset and single word:** hold `rst_ni` low, then release, then send one word 0xDEADBEEF.
  - During reset and after release: all outputs 0, `x.ready` = 1.
  - Next cycle: `rvalid_o` = 1, `rdata_o` = 0xDEADBEEF, `level_o` = 1, `xfer_cnt_o` = 1, `sum_o` = 0xDEADBEEF.
- **Fill:** push 1,2,3,4 back-to-back with no pop, DEPTH=4.
  - `level_o` = 4 and `x.ready` = 0.
  - A 5th word held valid is not accepted and `xfer_cnt_o` stays 4.
  - One pop: `rdata_o` 1→2 and `x.ready` rises the next cycle.
- **Steady streaming:** 100 words 0..99 with `x.valid` and `pop_i` continuously high.
  - Words are popped in order with no bubbles after the first.
  - Final `sum_o` = 4950 and `xfer_cnt_o` = 100.
- **Wrap-around:** with CNT_W=4, accept 18 words of 0xFFFFFFFF.
  - `xfer_cnt_o` = 2.
  - `sum_o` = 0xFFFFFFEE.
  - Pointer wrap preserves FIFO order.
- **Clear:** with 3 words buffered, pulse `clear_i` while `x.valid` and `pop_i` are high.
  - `x.ready` = 0 that cycle.
  - Next cycle: `level_o` = 0, `rvalid_o` = 0, counters 0, and no word was lost or duplicated.
- **Mid-operation reset:** pull `rst_ni` low asynchronously while `level_o` = 2.
  - Outputs clear before the next edge.
  - After release, new words are accepted normally.
